// File: rtl/pipearch_csr_dispatch.sv
// rtl/pipearch_csr_dispatch.sv - CSR staging, doorbell commit queue and engine command dispatch
// Optional watchdog: define PIPEARCH_CSR_DISPATCH_TIMEOUT_EN to abandon stalled commands.
module pipearch_csr_dispatch #(
    parameter int NUM_CSRS         = 4,
    parameter int NUM_ENGINES      = 2,
    parameter int DATA_WIDTH       = 64,
    parameter int QUEUE_DEPTH_LOG2 = 3,
    parameter int TIMEOUT_CYCLES   = 1024
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_CSRS-1:0]            csr_wr_en,
    input  logic [NUM_CSRS*DATA_WIDTH-1:0] csr_wr_data,
    output logic [NUM_ENGINES-1:0]         cmd_valid,
    input  logic [NUM_ENGINES-1:0]         cmd_ready,
    output logic [NUM_CSRS*DATA_WIDTH-1:0] cmd_data,
    output logic [QUEUE_DEPTH_LOG2:0]      queue_count,
    output logic                           queue_full,
    output logic [15:0]                    drop_count,
    output logic [15:0]                    bad_target_count,
    output logic [15:0]                    timeout_count
);

    localparam int CMD_W = NUM_CSRS * DATA_WIDTH;
    localparam int DEPTH = 1 << QUEUE_DEPTH_LOG2;
    localparam int DB    = NUM_CSRS - 1;
    localparam logic [QUEUE_DEPTH_LOG2:0] DEPTH_CNT = {1'b1, {QUEUE_DEPTH_LOG2{1'b0}}};

    typedef enum logic {
        S_IDLE,
        S_ISSUE
    } state_t;

    state_t                      state_q, state_d;
    logic [DATA_WIDTH-1:0]       staging [NUM_CSRS-1];
    logic [CMD_W-1:0]            queue_mem [DEPTH];
    logic [QUEUE_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [QUEUE_DEPTH_LOG2:0]   count_q;
    logic [CMD_W-1:0]            commit_entry;
    logic [CMD_W-1:0]            head;
    logic [7:0]                  head_target;
    logic                        head_target_ok;
    logic [NUM_ENGINES-1:0]      head_mask;
    logic [NUM_ENGINES-1:0]      mask_q, done_q, done_next, handshake;
    logic                        doorbell, full, push, pop, load_cmd, bad_pop;
    logic                        all_done, timer_hit, timeout_fire;
    logic [CMD_W-1:0]            cmd_data_q;

    assign doorbell    = csr_wr_en[DB];
    assign full        = (count_q == DEPTH_CNT);
    assign push        = doorbell && !full;
    assign head        = queue_mem[rd_ptr];
    assign head_target = head[DB*DATA_WIDTH +: 8];
    assign head_target_ok = (head_target == 8'hFF) || (int'(head_target) < NUM_ENGINES);

    assign cmd_valid   = (state_q == S_ISSUE) ? (mask_q & ~done_q) : '0;
    assign handshake   = cmd_valid & cmd_ready;
    assign done_next   = done_q | handshake;
    assign all_done    = ((mask_q & ~done_next) == '0);

    assign cmd_data    = cmd_data_q;
    assign queue_count = count_q;
    assign queue_full  = full;

    // Build the committed entry; same-cycle staging writes bypass the shadow registers
    always_comb begin
        commit_entry = '0;
        for (int i = 0; i < NUM_CSRS - 1; i++) begin
            commit_entry[i*DATA_WIDTH +: DATA_WIDTH] =
                csr_wr_en[i] ? csr_wr_data[i*DATA_WIDTH +: DATA_WIDTH] : staging[i];
        end
        commit_entry[DB*DATA_WIDTH +: DATA_WIDTH] = csr_wr_data[DB*DATA_WIDTH +: DATA_WIDTH];
    end

    // Decode the head target into an engine mask (0xFF broadcasts)
    always_comb begin
        head_mask = '0;
        for (int k = 0; k < NUM_ENGINES; k++) begin
            head_mask[k] = (head_target == 8'hFF) || (int'(head_target) == k);
        end
    end

`ifdef PIPEARCH_CSR_DISPATCH_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] timer_q;

    assign timer_hit = (timer_q >= TW'(TIMEOUT_CYCLES - 1));

    // Count cycles spent in ISSUE; restarts whenever a new command is loaded
    always_ff @(posedge clk) begin
        if (reset) begin
            timer_q <= '0;
        end else if (load_cmd) begin
            timer_q <= '0;
        end else if (state_q == S_ISSUE && !timer_hit) begin
            timer_q <= timer_q + 1'b1;
        end
    end

    // Saturating count of abandoned commands
    always_ff @(posedge clk) begin
        if (reset) begin
            timeout_count <= '0;
        end else if (timeout_fire && timeout_count != 16'hFFFF) begin
            timeout_count <= timeout_count + 16'd1;
        end
    end
`else
    assign timer_hit     = 1'b0;
    assign timeout_count = '0;
`endif

    // Dispatch FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: pop in IDLE, finish ISSUE when every targeted engine accepted;
    // a handshake in the watchdog cycle suppresses the abandon
    always_comb begin
        state_d      = state_q;
        pop          = 1'b0;
        load_cmd     = 1'b0;
        bad_pop      = 1'b0;
        timeout_fire = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop = 1'b1;
                    if (head_target_ok) begin
                        load_cmd = 1'b1;
                        state_d  = S_ISSUE;
                    end else begin
                        bad_pop = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                if (all_done) begin
                    state_d = S_IDLE;
                end else if (timer_hit && handshake == '0) begin
                    timeout_fire = 1'b1;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Queue storage; contents need no reset since pointers qualify them
    always_ff @(posedge clk) begin
        if (push) begin
            queue_mem[wr_ptr] <= commit_entry;
        end
    end

    // Staging, queue pointers, issued command, done tracking and event counters
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CSRS - 1; i++) begin
                staging[i] <= '0;
            end
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            count_q          <= '0;
            cmd_data_q       <= '0;
            mask_q           <= '0;
            done_q           <= '0;
            drop_count       <= '0;
            bad_target_count <= '0;
        end else begin
            for (int i = 0; i < NUM_CSRS - 1; i++) begin
                if (csr_wr_en[i]) begin
                    staging[i] <= csr_wr_data[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (load_cmd) begin
                cmd_data_q <= head;
                mask_q     <= head_mask;
                done_q     <= '0;
            end else if (state_q == S_ISSUE) begin
                done_q <= done_next;
            end
            if (doorbell && full && drop_count != 16'hFFFF) begin
                drop_count <= drop_count + 16'd1;
            end
            if (bad_pop && bad_target_count != 16'hFFFF) begin
                bad_target_count <= bad_target_count + 16'd1;
            end
        end
    end

endmodule

// File: doc/pipearch_csr_dispatch.md
Name: pipearch_csr_dispatch

Overview:
- Single-clock CSR command dispatcher. It sits after the CSR clock crossing and in front of multiple PipeArch engine instances.
- Stages per-CSR writes into a shadow set.
- A write to the last CSR (the doorbell) atomically commits the staged set into a command queue.
- The queue head is issued over a valid/ready handshake to one engine, or broadcast to all engines.
- Generalises per-CSR forwarding to N CSRs, M engines and a queued depth.

Parameters:
- NUM_CSRS, 4: CSR count. Index NUM_CSRS-1 is the doorbell. Minimum 2.
- NUM_ENGINES, 2: downstream engine count, 1..255.
- DATA_WIDTH, 64: bits per CSR.
- QUEUE_DEPTH_LOG2, 3: command queue holds 2^QUEUE_DEPTH_LOG2 entries.
- TIMEOUT_CYCLES, 1024: watchdog limit. Used only with the optional feature.

Ports:
- clk  in  1  sole clock.
- reset  in  1  synchronous, active-high.
- csr_wr_en  in  NUM_CSRS  per-CSR write strobe, 1-cycle pulse.
- csr_wr_data  in  NUM_CSRS*DATA_WIDTH  per-CSR data. CSR i occupies slice [i*DATA_WIDTH +: DATA_WIDTH].
- cmd_valid  out  NUM_ENGINES  per-engine command valid.
- cmd_ready  in  NUM_ENGINES  per-engine accept.
- cmd_data  out  NUM_CSRS*DATA_WIDTH  issued command, shared by all engines. Same slice layout as csr_wr_data.
- queue_count  out  QUEUE_DEPTH_LOG2+1  entries currently queued.
- queue_full  out  1  queue_count == 2^QUEUE_DEPTH_LOG2.
- drop_count  out  16  saturating count of commits lost to a full queue.
- bad_target_count  out  16  saturating count of commands with an invalid target.
- timeout_count  out  16  saturating count of watchdog abandons.

Behaviour:
- Reset: one clock, synchronous, active-high (clk/reset as above). Every output is 0 after the reset edge. Reset clears the staging registers, queue pointers, FSM state, done mask and all counters. A reset mid-issue drops the in-flight command with no partial completion.
- Staging: csr_wr_en[i] for i < NUM_CSRS-1 loads staging[i] at the next edge.
- Commit:
  - csr_wr_en[NUM_CSRS-1] pushes {doorbell data, staging[NUM_CSRS-2:0]} into the queue.
  - If a staging write and the doorbell occur in the same cycle, the new staging data is bypassed into the committed entry.
- Full queue: a commit while queue_full (registered value) is dropped and drop_count increments. This holds even if a pop occurs in the same cycle.
- Simultaneous push and pop: both take effect and queue_count is unchanged.
- Target field = doorbell bits [7:0]:
  - 0xFF: broadcast; target mask = all ones.
  - Value < NUM_ENGINES: one-hot mask.
  - Any other value: the command is popped and discarded, bad_target_count increments, and no cmd_valid is raised.
- FSM:
  - IDLE: if queue non-empty, pop the head into the cmd_data register, load target mask, clear done mask, go to ISSUE. An invalid target stays in IDLE.
  - ISSUE: cmd_valid = mask & ~done. On cmd_valid[k] && cmd_ready[k], set done[k] at the edge. When (mask & ~done_next) == 0, go to IDLE.
  - ISSUE to IDLE costs one bubble cycle before the next pop.
- cmd_data is held constant from entry to ISSUE until the return to IDLE.
- cmd_valid[k] never drops before acceptance, except on reset or watchdog abandon.
- Latency: doorbell at cycle t, with queue empty and FSM in IDLE, gives cmd_valid high in cycle t+2. A ready engine completes in cycle t+2, and the next command may assert in cycle t+4.
- Broadcast engines may accept in different cycles. Each engine sees exactly one handshake per command.
- Counters saturate at 0xFFFF.

Optional Feature:
- Macro: PIPEARCH_CSR_DISPATCH_TIMEOUT_EN.
- Defined:
  - A cycle counter resets on entry to ISSUE.
  - If it reaches TIMEOUT_CYCLES while still in ISSUE, all cmd_valid drop, timeout_count increments and the FSM returns to IDLE.
  - Acceptance in the same cycle as the timeout takes precedence: the handshake completes normally and no timeout is counted.
- Undefined: ISSUE waits indefinitely, no counter logic is synthesised, and timeout_count is tied to 0.

Test Plan:
- Write CSR0=0x11, CSR1=0x22, CSR2=0x33, then doorbell=0x01 with cmd_ready=2'b11 → cmd_valid=2'b10 two cycles after the doorbell; cmd_data slices 0x11/0x22/0x33/0x01; one handshake; queue_count returns to 0.
- Broadcast doorbell=0xFF; ready1 high immediately, ready0 high 5 cycles later → cmd_valid=2'b11, then 2'b01 after engine 1 accepts; exactly one handshake per engine; cmd_data stable throughout.
- CSR1=0xAB and doorbell=0x00 in the same cycle → committed slice1=0xAB, not the prior staged value.
- cmd_ready=0; 9 doorbells with QUEUE_DEPTH_LOG2=3 → 1 in ISSUE, 8 queued, queue_full=1, drop_count=0. A 10th doorbell → drop_count=1.
- Doorbell=0x05 with NUM_ENGINES=2 → bad_target_count=1, no cmd_valid. A following doorbell=0x00 still issues to engine 0.
- Macro defined, TIMEOUT_CYCLES=16, cmd_ready=0 → cmd_valid drops after 16 ISSUE cycles and timeout_count=1. A reset asserted mid-ISSUE instead → all outputs 0 at the next edge.
